mem_axi_master: RTL and testbench
=================================

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, data bus width; ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have these ports:
- axi_aclk  in  1  sole clock, rising edge.
- axi_areset  in  1  synchronous, active-high reset.
REQ-003 SHALL have core-side ports:
- mem_req  in  1  request valid.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_be  in  DATA_WIDTH/8  byte enables.
- mem_gnt  out  1  request accepted.
- mem_rvalid  out  1  completion pulse.
- mem_rdata  out  DATA_WIDTH  read data.
- mem_err  out  1  error response.
REQ-004 SHALL have AXI4-Lite master ports:
- write address: axi_awaddr, axi_awprot[2:0], axi_awvalid out; axi_awready in.
- write data: axi_wdata, axi_wstrb out; axi_wvalid out; axi_wready in.
- write response: axi_bresp[1:0], axi_bvalid in; axi_bready out.
- read address: axi_araddr, axi_arprot out; axi_arvalid out; axi_arready in.
- read data: axi_rdata, axi_rresp[1:0], axi_rvalid in; axi_rready out.

Function
REQ-005 SHALL allow at most one outstanding transaction.
REQ-006 SHALL assert mem_gnt combinationally only in IDLE when mem_req=1; mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be registered on that edge.
REQ-007 SHALL implement FSM states IDLE, WRITE, BRESP, RDADDR, RDATA.
- IDLE: on grant, go to WRITE if mem_we=1, else RDADDR.
- WRITE: go to BRESP after both AW and W handshakes complete.
- BRESP: return to IDLE on bvalid&bready.
- RDADDR: go to RDATA on arvalid&arready.
- RDATA: return to IDLE on rvalid&rready.
REQ-008 SHALL, in WRITE entry cycle, assert axi_awvalid and axi_wvalid together; write latency SHALL be one cycle from grant.
REQ-009 SHALL track AW and W completion independently; each valid SHALL drop the edge after its own handshake; handshakes SHALL be accepted in either order or the same cycle.
REQ-010 SHALL hold awaddr, wdata, wstrb and araddr stable while the corresponding valid is high; a valid, once asserted, SHALL NOT drop before its handshake.
REQ-011 SHALL drive axi_awaddr/axi_araddr with the captured byte address unmodified, axi_wstrb with mem_be, and axi_awprot/axi_arprot with 3'b000.
REQ-012 SHALL assert axi_bready only in BRESP and axi_rready only in RDATA.
REQ-013 SHALL pulse mem_rvalid for exactly one cycle, on the edge after the B or R handshake.
REQ-014 SHALL, in the mem_rvalid cycle:
- set mem_err = resp[1], so SLVERR and DECERR flag an error;
- set mem_rdata = the captured axi_rdata for reads, and 0 for writes.
REQ-015 SHALL NOT assert mem_gnt in the cycle mem_rvalid is high; the next grant SHALL be possible one cycle later.
REQ-016 SHALL ignore mem_req outside IDLE; the core SHALL hold mem_req until granted.

Reset
REQ-017 SHALL, while axi_areset=1, force FSM=IDLE and drive these outputs low on the next edge, regardless of any in-flight handshake:
- awvalid, wvalid, arvalid, bready, rready;
- mem_gnt, mem_rvalid, mem_err;
- mem_rdata=0.
REQ-018 SHALL, on reset mid-transaction, drop the transaction silently with no mem_rvalid; responses arriving after reset SHALL be ignored.

Structure
REQ-019 SHALL use shared package axi_lite_pkg for:
- the resp typedef: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
- the AXI_PROT_DEFAULT=3'b000 constant.
REQ-020 SHALL keep the FSM state typedef local to the module, with no sub-modules.

Verification
REQ-021 Write: req, we=1, addr=0x10, wdata=0xDEADBEEF, be=4'hF, slave ready=1.
- awvalid and wvalid rise the cycle after gnt; both handshake together.
- bresp=OKAY, then mem_rvalid=1 and mem_err=0 one cycle later.
REQ-022 Split write: slave raises wready 3 cycles before awready.
- wvalid drops after its handshake; awvalid and awaddr stay stable until accepted.
- A single B transaction and a single mem_rvalid follow.
REQ-023 Read: addr=0x10 after REQ-021, slave rvalid delayed 4 cycles.
- rready held throughout the wait.
- mem_rdata=0xDEADBEEF with mem_rvalid for one cycle.
REQ-024 Partial write: be=4'b0011, wdata=0x12345678 over 0xDEADBEEF; slave returns SLVERR on a later access.
- wstrb=4'b0011; readback=0xDEAD5678.
- The SLVERR access yields mem_err=1.
REQ-025 Reset: assert axi_areset while awvalid=1, before any handshake.
- All AXI valids and readies go low next edge; no mem_rvalid.
- The next request is granted immediately after reset deasserts.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions.
// Provides the response-code typedef, the default protection attribute and a helper
// that classifies a response code as an error.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(axi_resp_e resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/mem_axi_master.sv
// Simple core memory port to AXI4-Lite master bridge, one transaction in flight.
//
// Ports:
//   axi_aclk, axi_areset          clock, synchronous active-high reset
//   mem_req/we/addr/wdata/be      core request (held by core until mem_gnt)
//   mem_gnt                       combinational grant, only in IDLE
//   mem_rvalid/rdata/err          one-cycle completion pulse with read data / error
//   axi_aw*, axi_w*, axi_b*       AXI4-Lite write channels
//   axi_ar*, axi_r*               AXI4-Lite read channels
module mem_axi_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,

  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_gnt,
  output logic                    mem_rvalid,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_err,

  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,

  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,

  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,

  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,

  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StBresp,
    StRdaddr,
    StRdata
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]  be_q, be_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  mem_rvalid_q, mem_rvalid_d;
  logic                  mem_err_q, mem_err_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

  logic      done;
  axi_resp_e resp;

  // No grant in the completion cycle, so the core sees mem_rvalid before a new grant.
  assign mem_gnt = (state_q == StIdle) && mem_req && !mem_rvalid_q && !axi_areset;

  // B or R handshake this cycle; we_q tells which channel carries the response.
  assign done = ((state_q == StBresp) && axi_bvalid && bready_q) ||
                ((state_q == StRdata) && axi_rvalid && rready_q);
  assign resp = we_q ? axi_resp_e'(axi_bresp) : axi_resp_e'(axi_rresp);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    mem_rvalid_d = 1'b0;
    mem_err_d    = 1'b0;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (mem_gnt) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          be_d    = mem_be;
          if (mem_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrite;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdaddr;
          end
        end
      end
      StWrite: begin
        // AW and W retire independently, in any order or together.
        if (awvalid_q && axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StBresp;
        end
      end
      StBresp: begin
        if (done) begin
          bready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StRdaddr: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (done) begin
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      mem_rvalid_d = 1'b1;
      mem_err_d    = resp_is_err(resp);
      mem_rdata_d  = we_q ? '0 : axi_rdata;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_err_q    <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_err_q    <= mem_err_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign mem_rvalid  = mem_rvalid_q;
  assign mem_err     = mem_err_q;
  assign mem_rdata   = mem_rdata_q;

  assign axi_awaddr  = addr_q;
  assign axi_awprot  = AXI_PROT_DEFAULT;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = be_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = addr_q;
  assign axi_arprot  = AXI_PROT_DEFAULT;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed bench for mem_axi_master; the bench plays the AXI4-Lite slave.
module tb_mem_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  // Word-addressed backing store, written on W handshakes honouring strobes.
  logic [31:0] mem_model [0:15];

  always #5 clk = ~clk;

  mem_axi_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .axi_awaddr (awaddr),
    .axi_awprot (awprot),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_wdata  (wdata),
    .axi_wstrb  (wstrb),
    .axi_wvalid (wvalid),
    .axi_wready (wready),
    .axi_bresp  (bresp),
    .axi_bvalid (bvalid),
    .axi_bready (bready),
    .axi_araddr (araddr),
    .axi_arprot (arprot),
    .axi_arvalid(arvalid),
    .axi_arready(arready),
    .axi_rdata  (rdata),
    .axi_rresp  (rresp),
    .axi_rvalid (rvalid),
    .axi_rready (rready)
  );

  always @(posedge clk) begin
    if (wvalid && wready) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_model[awaddr[5:2]][8*b +: 8] = wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = data;
    mem_be    = be;
    #1;
    chk("gnt", {31'b0, mem_gnt}, 32'd1);
    tick();
    mem_req = 1'b0;
  endtask

  // Full write with an always-ready slave; checks completion pulse and error flag.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [1:0] resp, input logic exp_err);
    request(1'b1, addr, data, be);
    chk("wr_awvalid", {31'b0, awvalid}, 32'd1);
    chk("wr_wstrb", {28'b0, wstrb}, {28'b0, be});
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    chk("wr_bready", {31'b0, bready}, 32'd1);
    bvalid = 1'b1;
    bresp  = resp;
    tick();
    bvalid = 1'b0;
    chk("wr_rvalid", {31'b0, mem_rvalid}, 32'd1);
    chk("wr_err", {31'b0, mem_err}, {31'b0, exp_err});
    chk("wr_rdata", mem_rdata, 32'h0);
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] resp, input int delay,
                         input logic [31:0] exp_data, input logic exp_err);
    request(1'b0, addr, 32'h0, 4'h0);
    chk("rd_arvalid", {31'b0, arvalid}, 32'd1);
    chk("rd_araddr", araddr, addr);
    chk("rd_arprot", {29'b0, arprot}, 32'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rd_arvalid_drop", {31'b0, arvalid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      chk("rd_rready_wait", {31'b0, rready}, 32'd1);
      chk("rd_no_rvalid", {31'b0, mem_rvalid}, 32'd0);
      tick();
    end
    rvalid = 1'b1;
    rdata  = mem_model[addr[5:2]];
    rresp  = resp;
    tick();
    rvalid = 1'b0;
    chk("rd_rvalid", {31'b0, mem_rvalid}, 32'd1);
    chk("rd_rdata", mem_rdata, exp_data);
    chk("rd_err", {31'b0, mem_err}, {31'b0, exp_err});
    chk("rd_rready_drop", {31'b0, rready}, 32'd0);
    tick();
    chk("rd_pulse_end", {31'b0, mem_rvalid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
    rst = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_be = 4'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    tick();
    tick();
    // Reset state, with a request pending that must not be granted.
    chk("rst_gnt", {31'b0, mem_gnt}, 32'd0);
    chk("rst_awvalid", {31'b0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'b0, wvalid}, 32'd0);
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_bready", {31'b0, bready}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_rvalid", {31'b0, mem_rvalid}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    mem_req = 1'b0;
    rst = 1'b0;
    tick();

    // Simple write, both channels accept in the same cycle.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF; mem_be = 4'hF;
    #1;
    chk("w1_gnt", {31'b0, mem_gnt}, 32'd1);
    chk("w1_aw_before", {31'b0, awvalid}, 32'd0);
    awready = 1'b1; wready = 1'b1;
    tick();
    mem_req = 1'b0;
    chk("w1_awvalid", {31'b0, awvalid}, 32'd1);
    chk("w1_wvalid", {31'b0, wvalid}, 32'd1);
    chk("w1_awaddr", awaddr, 32'h10);
    chk("w1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_wstrb", {28'b0, wstrb}, 32'hF);
    chk("w1_awprot", {29'b0, awprot}, 32'd0);
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("w1_aw_drop", {31'b0, awvalid}, 32'd0);
    chk("w1_w_drop", {31'b0, wvalid}, 32'd0);
    chk("w1_bready", {31'b0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("w1_rvalid", {31'b0, mem_rvalid}, 32'd1);
    chk("w1_err", {31'b0, mem_err}, 32'd0);
    chk("w1_bready_drop", {31'b0, bready}, 32'd0);

    // Next request presented in the completion cycle: grant waits one cycle.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hCAFEF00D; mem_be = 4'hF;
    #1;
    chk("w2_no_gnt_in_rvalid", {31'b0, mem_gnt}, 32'd0);
    tick();
    chk("w2_pulse_end", {31'b0, mem_rvalid}, 32'd0);
    chk("w2_gnt", {31'b0, mem_gnt}, 32'd1);
    tick();
    mem_req = 1'b0;
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("w2_w_drop", {31'b0, wvalid}, 32'd0);
    chk("w2_aw_hold1", {31'b0, awvalid}, 32'd1);
    tick();
    chk("w2_aw_hold2", {31'b0, awvalid}, 32'd1);
    chk("w2_awaddr", awaddr, 32'h20);
    chk("w2_no_bready", {31'b0, bready}, 32'd0);
    tick();
    chk("w2_aw_hold3", {31'b0, awvalid}, 32'd1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("w2_aw_drop", {31'b0, awvalid}, 32'd0);
    chk("w2_bready", {31'b0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("w2_rvalid", {31'b0, mem_rvalid}, 32'd1);
    tick();
    chk("w2_single_pulse", {31'b0, mem_rvalid}, 32'd0);
    chk("w2_mem", mem_model[8], 32'hCAFEF00D);

    // Read back with a 4-cycle slave delay.
    do_read(32'h10, 2'b00, 4, 32'hDEADBEEF, 1'b0);

    // Partial write, then readback merges old and new bytes.
    do_write(32'h10, 32'h12345678, 4'b0011, 2'b00, 1'b0);
    do_read(32'h10, 2'b00, 1, 32'hDEAD5678, 1'b0);

    // Error responses on both channels.
    do_read(32'h40, 2'b10, 0, 32'h0, 1'b1);
    do_write(32'h24, 32'h0000AAAA, 4'hF, 2'b11, 1'b1);
    do_write(32'h28, 32'h0000BBBB, 4'hF, 2'b01, 1'b0);

    // Reset while awvalid is pending, before any handshake.
    request(1'b1, 32'h30, 32'h55555555, 4'hF);
    chk("rs_awvalid", {31'b0, awvalid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rs_awvalid_low", {31'b0, awvalid}, 32'd0);
    chk("rs_wvalid_low", {31'b0, wvalid}, 32'd0);
    chk("rs_bready_low", {31'b0, bready}, 32'd0);
    chk("rs_rvalid_low", {31'b0, mem_rvalid}, 32'd0);
    rst = 1'b0;
    // Stray response after reset must be ignored; a new read is granted at once.
    bvalid = 1'b1; bresp = 2'b00;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
    #1;
    chk("rs_gnt_now", {31'b0, mem_gnt}, 32'd1);
    tick();
    mem_req = 1'b0;
    chk("rs_arvalid", {31'b0, arvalid}, 32'd1);
    chk("rs_no_rvalid", {31'b0, mem_rvalid}, 32'd0);
    chk("rs_no_bready", {31'b0, bready}, 32'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    bvalid  = 1'b0;
    chk("rs_no_rvalid2", {31'b0, mem_rvalid}, 32'd0);
    rvalid = 1'b1; rdata = mem_model[4]; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("rs_rd_rvalid", {31'b0, mem_rvalid}, 32'd1);
    chk("rs_rd_rdata", mem_rdata, 32'hDEAD5678);
    chk("rs_mem30", mem_model[12], 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
